// File: rtl/receiver_if.sv
//------------------------------------------------------------------------------
// Module      : receiver_if
// Description : Parallel-side handshake and serial-line bundle for receiver.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface receiver_if #(
    parameter int DATA_W = 8
);
    logic              cen;
    logic              si;
    logic              rd;
    logic [DATA_W-1:0] par_out;
    logic              valid;
    logic              frm_err;
    logic              ovr;

    modport master (
        output cen, si, rd,
        input  par_out, valid, frm_err, ovr
    );

    modport slave (
        input  cen, si, rd,
        output par_out, valid, frm_err, ovr
    );
endinterface

`default_nettype wire

// File: rtl/receiver.sv
//------------------------------------------------------------------------------
// Module      : receiver
// Description : Serial-to-parallel receiver, LSB-first frames with start/stop
//               bits, valid/rd handshake, framing-error pulse, sticky overrun.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module receiver #(
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    receiver_if.slave  bus
);
    localparam int C_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DATA_W - 1);
    localparam logic [C_CNT_W-1:0] C_ONE  = C_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DATA    = 2'd1,
        S_STOP    = 2'd2,
        S_WAIT_HI = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [C_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_sr, w_sr_nxt;
    logic [DATA_W-1:0]   r_par_out, w_par_out_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_frm_err, w_frm_err_nxt;
    logic                r_ovr, w_ovr_nxt;
    logic                w_ack;

    assign w_ack = r_valid & bus.rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sr      <= '0;
            r_par_out <= '0;
            r_valid   <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sr      <= w_sr_nxt;
            r_par_out <= w_par_out_nxt;
            r_valid   <= w_valid_nxt;
            r_frm_err <= w_frm_err_nxt;
            r_ovr     <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_sr_nxt      = r_sr;
        w_par_out_nxt = r_par_out;
        w_valid_nxt   = r_valid;
        w_frm_err_nxt = 1'b0;
        w_ovr_nxt     = r_ovr;

        // Acknowledge runs every clock; a good frame below may override it.
        if (w_ack) begin
            w_valid_nxt = 1'b0;
            w_ovr_nxt   = 1'b0;
        end

        if (bus.cen) begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.si) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    w_sr_nxt  = {bus.si, r_sr[DATA_W-1:1]};
                    w_cnt_nxt = r_cnt + C_ONE;
                    if (r_cnt == C_LAST) begin
                        w_state_nxt = S_STOP;
                    end
                end
                S_STOP: begin
                    if (bus.si) begin
                        if (!r_valid || bus.rd) begin
                            w_par_out_nxt = r_sr;
                            w_valid_nxt   = 1'b1;
                        end else begin
                            w_ovr_nxt = 1'b1;
                        end
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frm_err_nxt = 1'b1;
                        w_state_nxt   = S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    // A low line here is the tail of a broken frame, not a start bit.
                    if (bus.si) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bus.par_out = r_par_out;
    assign bus.valid   = r_valid;
    assign bus.frm_err = r_frm_err;
    assign bus.ovr     = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_receiver.sv
//------------------------------------------------------------------------------
// Module      : tb_receiver
// Description : Scoreboard bench for receiver with a frame-level reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_receiver;
    logic clk;
    logic rst;

    receiver_if #(.DATA_W(8)) bus ();

    receiver #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Frame-level information published by the driver for the model.
    int         f_kind;     // 0 none, 1 good stop bit this edge, 2 bad stop bit this edge
    logic [7:0] cur_word;
    logic       rd_auto;

    // Reference model: one pending-word slot, sticky overrun, error pulse.
    logic       m_valid;
    logic       m_ovr;
    logic       m_ferr;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
            m_ferr  <= 1'b0;
            exp_q.delete();
        end else begin
            m_ferr <= (f_kind == 2);
            if (f_kind == 1) begin
                if (!m_valid || bus.rd) begin
                    m_valid <= 1'b1;
                    exp_q.push_back(cur_word);
                    if (m_valid) m_ovr <= 1'b0;
                end else begin
                    m_ovr <= 1'b1;
                end
            end else if (m_valid && bus.rd) begin
                m_valid <= 1'b0;
                m_ovr   <= 1'b0;
            end
        end
    end

    // Monitor: status every cycle, pop a word whenever one is acknowledged.
    always @(negedge clk) begin
        logic [7:0] e;
        chk("valid", {31'd0, bus.valid}, {31'd0, m_valid});
        chk("ovr", {31'd0, bus.ovr}, {31'd0, m_ovr});
        chk("frm_err", {31'd0, bus.frm_err}, {31'd0, m_ferr});
        if (bus.valid && bus.rd) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {24'd0, bus.par_out}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("par_out", {24'd0, bus.par_out}, {24'd0, e});
            end
        end
    end

    task automatic drive_rd(input logic v);
        bus.rd = rd_auto ? ($urandom_range(0, 2) == 0) : v;
    endtask

    task automatic bit_cycle(input logic b, input int idles, input int kind, input logic rd_v);
        for (int k = 0; k < idles; k++) begin
            bus.cen = 1'b0;
            bus.si  = 1'($urandom_range(0, 1));
            drive_rd(1'b0);
            f_kind  = 0;
            @(posedge clk); #1;
        end
        bus.cen = 1'b1;
        bus.si  = b;
        drive_rd(rd_v);
        f_kind  = kind;
        @(posedge clk); #1;
        f_kind  = 0;
    endtask

    function automatic int pick_gap(input int g);
        return (g < 0) ? int'($urandom_range(0, 3)) : g;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop, input int g,
                              input int tail, input logic rd_stop);
        cur_word = d;
        bit_cycle(1'b0, pick_gap(g), 0, 1'b0);
        for (int i = 0; i < 8; i++) bit_cycle(d[i], pick_gap(g), 0, 1'b0);
        bit_cycle(stop, pick_gap(g), stop ? 1 : 2, rd_stop);
        if (!stop) begin
            for (int i = 0; i < tail; i++) bit_cycle(1'b0, pick_gap(g), 0, 1'b0);
            bit_cycle(1'b1, pick_gap(g), 0, 1'b0);
        end
    endtask

    task automatic idle(input int n, input logic rd_v);
        for (int i = 0; i < n; i++) bit_cycle(1'b1, 0, 0, rd_v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        bus.cen  = 1'b0;
        bus.si   = 1'b1;
        bus.rd   = 1'b0;
        rd_auto  = 1'b0;
        f_kind   = 0;
        cur_word = 8'h00;

        // Reset with random line activity
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.cen = 1'($urandom_range(0, 1));
            bus.si  = 1'($urandom_range(0, 1));
        end
        bus.cen = 1'b0;
        bus.si  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_frm_err", {31'd0, bus.frm_err}, 32'd0);
        chk("rst_ovr", {31'd0, bus.ovr}, 32'd0);
        chk("rst_par_out", {24'd0, bus.par_out}, 32'd0);

        // Good frame, continuous cen
        send_frame(8'h0D, 1'b1, 0, 0, 1'b0);
        chk("good_valid", {31'd0, bus.valid}, 32'd1);
        chk("good_par", {24'd0, bus.par_out}, 32'h0D);
        idle(1, 1'b1);
        chk("good_ack_valid", {31'd0, bus.valid}, 32'd0);

        // Sparse cen with glitches between enables
        send_frame(8'h0D, 1'b1, 2, 0, 1'b0);
        chk("sparse_valid", {31'd0, bus.valid}, 32'd1);
        chk("sparse_par", {24'd0, bus.par_out}, 32'h0D);
        idle(1, 1'b1);

        // Framing error, low tail, then a clean frame
        send_frame(8'hA5, 1'b0, 0, 3, 1'b0);
        chk("ferr_valid", {31'd0, bus.valid}, 32'd0);
        send_frame(8'h3C, 1'b1, 0, 0, 1'b0);
        chk("after_ferr_par", {24'd0, bus.par_out}, 32'h3C);
        idle(1, 1'b1);

        // Overrun then acknowledge
        send_frame(8'h11, 1'b1, 0, 0, 1'b0);
        send_frame(8'h22, 1'b1, 0, 0, 1'b0);
        chk("ovr_set", {31'd0, bus.ovr}, 32'd1);
        chk("ovr_par", {24'd0, bus.par_out}, 32'h11);
        idle(1, 1'b1);
        chk("ovr_ack_valid", {31'd0, bus.valid}, 32'd0);
        chk("ovr_ack_ovr", {31'd0, bus.ovr}, 32'd0);

        // Acknowledge coinciding with a good stop bit while overrun is set
        send_frame(8'h11, 1'b1, 0, 0, 1'b0);
        send_frame(8'h22, 1'b1, 0, 0, 1'b0);
        send_frame(8'h7E, 1'b1, 0, 0, 1'b1);
        chk("simul_par", {24'd0, bus.par_out}, 32'h7E);
        chk("simul_valid", {31'd0, bus.valid}, 32'd1);
        chk("simul_ovr", {31'd0, bus.ovr}, 32'd0);
        idle(1, 1'b1);

        // Reset in the middle of a frame
        bit_cycle(1'b0, 0, 0, 1'b0);
        bit_cycle(1'b1, 0, 0, 1'b0);
        bit_cycle(1'b0, 0, 0, 1'b0);
        rst = 1'b0;
        bus.cen = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", {31'd0, bus.valid}, 32'd0);
        rst = 1'b1;
        idle(1, 1'b0);
        send_frame(8'h5A, 1'b1, 0, 0, 1'b0);
        chk("midrst_par", {24'd0, bus.par_out}, 32'h5A);
        idle(1, 1'b1);

        // Randomized traffic with random acknowledges and occasional bad stops
        rd_auto = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom), ($urandom_range(0, 7) != 0), -1,
                       int'($urandom_range(0, 3)), 1'b0);
        end
        rd_auto = 1'b0;
        idle(3, 1'b1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/receiver.md
# receiver

Serial-to-parallel receiver at the far end of the serial link driven by the `transmitter` / `transmitter_PP` blocks. It watches the one-bit serial line, detects a start bit, and shifts in one data word LSB-first. It checks the stop bit and presents the word on a parallel port with a valid/acknowledge handshake. It also reports framing and overrun errors. It is the front end for the downstream sequence detector.

## Interface
- `DATA_W`, default 8: data bits per frame.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset (0 = reset).
- `cen`  in  1: bit-rate enable. Exactly one serial bit is consumed per cycle with `cen`=1.
- `si`  in  1: serial line, idle high.
- `rd`  in  1: consumer acknowledge of `par_out`.
- `par_out`  out  DATA_W: last accepted word.
- `valid`  out  1: `par_out` holds an unacknowledged word.
- `frm_err`  out  1: one-cycle pulse on a bad stop bit.
- `ovr`  out  1: sticky overrun flag.

## Operation
- Frame format on `si`: start bit 0, then DATA_W data bits LSB first, then stop bit 1. One bit per `cen` cycle.
- The FSM has four states: IDLE, DATA, STOP and WAIT_HI. All transitions and shifts happen only on edges where `cen`=1. With `cen`=0 the FSM, shift register and bit counter hold.
- IDLE: if `si`=0, clear the bit counter and go to DATA. If `si`=1, stay.
- DATA: shift reg <= {`si`, sr[DATA_W-1:1]} and increment the counter. When the counter reaches DATA_W-1 on this edge, go to STOP.
- STOP, `si`=1 (good frame), then go to IDLE:
  - If `valid`=0, or `rd`=1 on this cycle: `par_out` <= sr and `valid` <= 1.
  - Otherwise drop the frame, keep `par_out` unchanged, and set `ovr` <= 1.
- STOP, `si`=0 (bad frame): discard the word, pulse `frm_err`=1 for one clk cycle, and go to WAIT_HI.
- WAIT_HI: stay until a `cen` cycle with `si`=1, then go to IDLE. A low line after a bad stop bit is never treated as a start bit.
- Handshake:
  - `rd`=1 while `valid`=1 acknowledges the word. `valid` falls on the next edge unless a good frame completes on that same edge; in that case the new word loads and `valid` stays 1.
  - `rd` while `valid`=0 is ignored.
  - The acknowledge is independent of `cen`.
- `ovr` clears on an accepted `rd` (the edge where `valid`=1 and `rd`=1).
- Reset values (asynchronous, while `rst`=0): state IDLE, counter 0, shift register 0, `par_out`=0, `valid`=0, `frm_err`=0, `ovr`=0.
- Reset mid-frame aborts the frame with no `valid` or error. After `rst` returns to 1, reception restarts from IDLE.

## Timing
- Sampling: `si` is sampled at the rising `clk` edge of each `cen`=1 cycle. `si` must be stable around that edge. There is no oversampling and no synchronizer; `si` is assumed synchronous to `clk`.
- Latency: `valid` and `par_out` update on the same edge that samples a good stop bit. From the start-bit edge that is DATA_W+1 further `cen` edges.
- Back-to-back frames are supported: a start bit may be sampled on the very next `cen` cycle after the stop bit.
- `frm_err` is high for exactly one `clk` cycle after the edge that samples the bad stop bit, regardless of `cen`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold `rst`=0 with random `si`/`cen`, then release → `valid`=0, `frm_err`=0, `ovr`=0, `par_out`=0x00.
- **Good frame:** `cen`=1 every cycle, `si` = 0,1,0,1,1,0,0,0,0,1 (0x0D) → `valid`=1 and `par_out`=0x0D on the stop-bit edge. `rd` pulse → `valid`=0 next cycle.
- **Sparse `cen`:** same 0x0D frame with `cen` high only every 3rd cycle, and `si` glitching during `cen`=0 cycles → `par_out`=0x0D. There is no early or extra shift.
- **Framing error:** 0xA5 frame with stop bit 0, `si` held low 3 more `cen` cycles, then high, then a 0x3C frame:
  - `frm_err` is a single pulse and `valid` stays 0 for the bad frame.
  - The low tail is not taken as a start bit.
  - Then `par_out`=0x3C.
- **Overrun:** receive 0x11 with no `rd`, then 0x22 → `ovr`=1 and `par_out` stays 0x11. `rd` → `valid`=0 and `ovr`=0.
- **Simultaneous:** `rd`=1 on the same edge as the good stop bit of 0x7E while 0x11 is pending → `par_out`=0x7E, `valid` stays 1, `ovr`=0.
